id_ex_stage: RTL

- Decode-to-execute pipeline register for the simple 32-bit processor; drives the ALU's data0, data1 and alu_op.
- Captures register-file operands, sign-extends the immediate and resolves the 3-bit ALU control from the op class and funct.
- Forwards in-flight results from EX/MEM and MEM/WB.
- Supports stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/alu_ctrl_dec.sv | 41 ++++
 rtl/id_ex_stage.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared definitions for the simple 32-bit processor: datapath
//               widths, op_class encodings, R-type funct codes and ALU control
//               codes. Imported by the ID/EX stage, the ALU control decoder
//               and the single-cycle datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Default datapath and register-index widths
    localparam int C_DW = 32;
    localparam int C_RW = 5;

    // Operation class produced by the main decoder
    localparam logic [1:0] OPC_ADD   = 2'b00;  // lw / sw address computation
    localparam logic [1:0] OPC_SUB   = 2'b01;  // beq comparison
    localparam logic [1:0] OPC_RTYPE = 2'b10;  // ALU function taken from funct
    localparam logic [1:0] OPC_RSVD  = 2'b11;  // reserved, decodes to ALU_NONE

    // R-type function field values
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_NONE = 3'b011;  // ALU default path, result 0
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/alu_ctrl_dec.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_dec
// Description : Combinational ALU control decoder. Maps the op class from the
//               main decoder and the R-type funct field to the 3-bit ALU
//               control code. Unknown functs and the reserved class decode
//               to ALU_NONE so the ALU produces 0.
// Ports       : op_class [1:0] in  - operation class
//               funct    [5:0] in  - R-type function field
//               alu_op   [2:0] out - ALU control
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_dec
    import cpu_pkg::*;
(
    input  logic [1:0] op_class,
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_NONE;
        case (op_class)
            OPC_ADD: alu_op = ALU_ADD;
            OPC_SUB: alu_op = ALU_SUB;
            OPC_RTYPE: begin
                case (funct)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_SLT:   alu_op = ALU_SLT;
                    default: alu_op = ALU_NONE;
                endcase
            end
            default: alu_op = ALU_NONE;
        endcase
    end

endmodule : alu_ctrl_dec
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Decode-to-execute pipeline register. Captures the register
//               file operands (optionally forwarded from EX/MEM and MEM/WB),
//               sign-extends the immediate, selects ALU operand B, resolves
//               the ALU control and the destination index. Supports stall
//               (hold) and flush (bubble); priority rst > flush > stall > load.
// Config      : ID_EX_FWD_EN - when defined, operands are forwarded from
//               EX/MEM (highest priority) then MEM/WB; register 0 is never
//               forwarded. When undefined, operands come straight from the
//               register file and the exm_*/wb_* ports are ignored.
// Ports       : clk, rst (async, active high), stall, flush
//               decode inputs : in_valid, rs_data, rt_data, imm, alu_src,
//                               op_class, funct, rs_idx, rt_idx, rd_idx,
//                               reg_dst, reg_write
//               forwarding    : exm_reg_write, exm_rd, exm_result,
//                               wb_reg_write, wb_rd, wb_result
//               execute outs  : ex_valid, data0, data1, alu_op,
//                               ex_store_data, ex_rd, ex_reg_write
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW = C_DW,
    parameter int RW = C_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] rs_data,
    input  logic [DW-1:0] rt_data,
    input  logic [15:0]   imm,
    input  logic          alu_src,
    input  logic [1:0]    op_class,
    input  logic [5:0]    funct,
    input  logic [RW-1:0] rs_idx,
    input  logic [RW-1:0] rt_idx,
    input  logic [RW-1:0] rd_idx,
    input  logic          reg_dst,
    input  logic          reg_write,
    input  logic          exm_reg_write,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_reg_write,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_result,
    output logic          ex_valid,
    output logic [DW-1:0] data0,
    output logic [DW-1:0] data1,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_rd,
    output logic          ex_reg_write
);

    logic [DW-1:0] w_rs_res;
    logic [DW-1:0] w_rt_res;
    logic [DW-1:0] w_imm_ext;
    logic [2:0]    w_alu_op;

    logic          r_valid;
    logic [DW-1:0] r_data0;
    logic [DW-1:0] r_data1;
    logic [2:0]    r_alu_op;
    logic [DW-1:0] r_store;
    logic [RW-1:0] r_rd;
    logic          r_reg_write;

`ifdef ID_EX_FWD_EN
    // EX/MEM is the younger result, so it wins over MEM/WB.
    always_comb begin
        w_rs_res = rs_data;
        if (exm_reg_write && (exm_rd == rs_idx) && (rs_idx != '0))
            w_rs_res = exm_result;
        else if (wb_reg_write && (wb_rd == rs_idx) && (rs_idx != '0))
            w_rs_res = wb_result;
    end

    always_comb begin
        w_rt_res = rt_data;
        if (exm_reg_write && (exm_rd == rt_idx) && (rt_idx != '0))
            w_rt_res = exm_result;
        else if (wb_reg_write && (wb_rd == rt_idx) && (rt_idx != '0))
            w_rt_res = wb_result;
    end
`else
    // Forwarding ports stay on the interface but feed nothing.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{exm_reg_write, exm_rd, exm_result,
                            wb_reg_write, wb_rd, wb_result, rs_idx};
    assign w_rs_res = rs_data;
    assign w_rt_res = rt_data;
`endif

    assign w_imm_ext = {{(DW-16){imm[15]}}, imm};

    alu_ctrl_dec u_alu_ctrl_dec (
        .op_class (op_class),
        .funct    (funct),
        .alu_op   (w_alu_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_data0     <= '0;
            r_data1     <= '0;
            r_alu_op    <= ALU_AND;
            r_store     <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
        end else if (flush || (!stall && !in_valid)) begin
            // Bubble: everything zero, alu_op 000 is a harmless AND.
            r_valid     <= 1'b0;
            r_data0     <= '0;
            r_data1     <= '0;
            r_alu_op    <= ALU_AND;
            r_store     <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
        end else if (!stall) begin
            r_valid     <= 1'b1;
            r_data0     <= w_rs_res;
            r_data1     <= alu_src ? w_imm_ext : w_rt_res;
            r_alu_op    <= w_alu_op;
            r_store     <= w_rt_res;
            r_rd        <= reg_dst ? rd_idx : rt_idx;
            r_reg_write <= reg_write;
        end
    end

    assign ex_valid      = r_valid;
    assign data0         = r_data0;
    assign data1         = r_data1;
    assign alu_op        = r_alu_op;
    assign ex_store_data = r_store;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;

endmodule : id_ex_stage
`default_nettype wire
